// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave: the arbiter's view; master: the CPU/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [STRB_W-1:0]     d_wstrb;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_W-1:0]     mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data requests onto one fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On a tie, whoever was not served last wins; a lone requester always wins.
    always_comb begin
        grant_data = bus.d_req && (!bus.if_req || (last_owner_q == OWN_FETCH));
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if ((state_q == IDLE) && (bus.if_req || bus.d_req)) begin
            last_owner_d = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_FETCH;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_comb begin
        grant_data = bus.d_req;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_d = ISSUE;
                    if (grant_data) begin
                        owner_d = OWN_DATA;
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                        // Byte enables are forced low on loads so reads never carry strobes.
                        wstrb_d = bus.d_we ? bus.d_wstrb : '0;
                    end else begin
                        owner_d = OWN_FETCH;
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_DATA) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_FETCH;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // The memory strobe and done pulses are pure state decodes, so each lasts one cycle.
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.if_done   = (state_q == RESP) && (owner_q == OWN_FETCH);
    assign bus.d_done    = (state_q == RESP) && (owner_q == OWN_DATA);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: latency-1 instance with a byte-strobed memory model,
// plus a latency-3 instance for the long-latency timing case.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1();
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 4) return 32'h0050_0093;
        return {b, 8'h5A, ~b, 8'hC3};
    endfunction

    // Latency-1 memory: read data is valid only in the cycle after mem_en, garbage otherwise.
    logic [31:0] mem [0:255];
    logic [31:0] mem_rd;
    assign bus1.mem_rdata = mem_rd;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem_rd = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            if (bus1.mem_en && bus1.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus1.mem_wstrb[b]) mem[bus1.mem_addr[9:2]][b*8 +: 8] = bus1.mem_wdata[b*8 +: 8];
                mem_rd <= 32'hBAD0_BAD0;
            end else if (bus1.mem_en) begin
                mem_rd <= mem[bus1.mem_addr[9:2]];
            end else begin
                mem_rd <= 32'hBAD0_BAD0;
            end
        end
    end

    // Latency-3 memory: returns a function of the address three cycles after mem_en.
    logic [31:0] p3 [0:2];
    assign bus3.mem_rdata = p3[2];
    always @(posedge clk) begin
        p3[0] <= (bus3.mem_en && !bus3.mem_we) ? (bus3.mem_addr ^ 32'hA5A5_0000) : 32'hBAD0_BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sb3[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_d_rdata = '0;
    bit          last_owner = 1'b0;
    int          n_txn = 0;
    int          en1_cnt = 0;

    always @(negedge clk) begin
        if (bus1.mem_en) begin
            en1_cnt++;
            if (!bus1.mem_we) check_val("rd_wstrb_zero", {28'd0, bus1.mem_wstrb}, 32'd0);
        end
        if (bus1.if_done || bus1.d_done) begin
            check_val("done_exclusive", {31'd0, bus1.if_done & bus1.d_done}, 32'd0);
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("owner", {31'd0, bus1.d_done}, {31'd0, e.owner});
                if (e.owner) check_val("d_rdata", bus1.d_rdata, e.data);
                else         check_val("if_rdata", bus1.if_rdata, e.data);
            end
        end
    end

    task automatic push_exp(input bit owner, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
        exp_t e;
        int   idx;
        idx     = int'(addr[9:2]);
        e.owner = owner;
        if (!owner) begin
            e.data = ref_mem[idx];
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
            e.data = exp_d_rdata;
        end else begin
            e.data      = ref_mem[idx];
            exp_d_rdata = e.data;
        end
        last_owner = owner;
        n_txn++;
        sb.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        int unsigned t0;
        bit          got;
        @(negedge clk);
        bus1.if_req  = 1'b1;
        bus1.if_addr = addr;
        push_exp(1'b0, 1'b0, addr, 32'd0, 4'd0);
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check_val("fetch_busy", {31'd0, bus1.busy}, 32'd1);
            if (bus1.if_done) begin
                got = 1'b1;
                break;
            end
        end
        check_val("fetch_done_seen", {31'd0, got}, 32'd1);
        if (got) check_val("fetch_latency", cyc - t0, 32'd3);
        bus1.if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
        int unsigned t0;
        bit          got;
        @(negedge clk);
        bus1.d_req   = 1'b1;
        bus1.d_we    = we;
        bus1.d_addr  = addr;
        bus1.d_wdata = wdata;
        bus1.d_wstrb = strb;
        push_exp(1'b1, we, addr, wdata, strb);
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.d_done) begin
                got = 1'b1;
                break;
            end
        end
        check_val("data_done_seen", {31'd0, got}, 32'd1);
        if (got) check_val("data_latency", cyc - t0, 32'd3);
        bus1.d_req = 1'b0;
    endtask

    task automatic do_tie(input logic [31:0] fa, input logic [31:0] da);
        bit          data_first;
        bit          fd;
        bit          dd;
        int unsigned tf;
        int unsigned td;
`ifdef ARB_ROUND_ROBIN_EN
        data_first = (last_owner == 1'b0);
`else
        data_first = 1'b1;
`endif
        fd = 1'b0;
        dd = 1'b0;
        tf = 0;
        td = 0;
        @(negedge clk);
        bus1.if_req  = 1'b1;
        bus1.if_addr = fa;
        bus1.d_req   = 1'b1;
        bus1.d_we    = 1'b0;
        bus1.d_addr  = da;
        if (data_first) begin
            push_exp(1'b1, 1'b0, da, 32'd0, 4'd0);
            push_exp(1'b0, 1'b0, fa, 32'd0, 4'd0);
        end else begin
            push_exp(1'b0, 1'b0, fa, 32'd0, 4'd0);
            push_exp(1'b1, 1'b0, da, 32'd0, 4'd0);
        end
        for (int i = 0; i < 30 && !(fd && dd); i++) begin
            @(negedge clk);
            if (bus1.if_done) begin
                fd = 1'b1;
                tf = cyc;
                bus1.if_req = 1'b0;
            end
            if (bus1.d_done) begin
                dd = 1'b1;
                td = cyc;
                bus1.d_req = 1'b0;
            end
        end
        bus1.if_req = 1'b0;
        bus1.d_req  = 1'b0;
        check_val("tie_both_done", {30'd0, fd, dd}, 32'd3);
        if (fd && dd) check_val("tie_gap", data_first ? (tf - td) : (td - tf), 32'd4);
    endtask

    initial begin
        int unsigned t0;
        int          en3;
        bit          got;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.d_req  = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_wstrb = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0;
        bus3.d_req  = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_wstrb = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy",      {31'd0, bus1.busy},    32'd0);
        check_val("rst_mem_en",    {31'd0, bus1.mem_en},  32'd0);
        check_val("rst_mem_we",    {31'd0, bus1.mem_we},  32'd0);
        check_val("rst_if_done",   {31'd0, bus1.if_done}, 32'd0);
        check_val("rst_d_done",    {31'd0, bus1.d_done},  32'd0);
        check_val("rst_mem_addr",  bus1.mem_addr,         32'd0);
        check_val("rst_mem_wdata", bus1.mem_wdata,        32'd0);
        check_val("rst_mem_wstrb", {28'd0, bus1.mem_wstrb}, 32'd0);
        check_val("rst_if_rdata",  bus1.if_rdata,         32'd0);
        check_val("rst_d_rdata",   bus1.d_rdata,          32'd0);
        rst = 1'b0;

        do_fetch(32'h10);
        do_data(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b1111);
        do_data(1'b0, 32'h40, 32'd0, 4'd0);
        do_data(1'b1, 32'h40, 32'h1122_3344, 4'b0101);
        do_data(1'b0, 32'h40, 32'd0, 4'd0);
        do_fetch(32'h44);
        do_data(1'b1, 32'h80, 32'hCAFE_F00D, 4'b1000);

        do_tie(32'h10, 32'h40);
        do_tie(32'h14, 32'h80);
        do_tie(32'h18, 32'h1C);

        // Abort a fetch while it waits on memory; no done may follow.
        @(negedge clk);
        bus1.if_req  = 1'b1;
        bus1.if_addr = 32'h20;
        @(negedge clk);
        check_val("abort_issue_en", {31'd0, bus1.mem_en}, 32'd1);
        @(negedge clk);
        check_val("abort_in_wait", {31'd0, bus1.busy}, 32'd1);
        rst          = 1'b1;
        bus1.if_req  = 1'b0;
        @(negedge clk);
        check_val("abort_busy",    {31'd0, bus1.busy},    32'd0);
        check_val("abort_mem_en",  {31'd0, bus1.mem_en},  32'd0);
        check_val("abort_if_done", {31'd0, bus1.if_done}, 32'd0);
        check_val("abort_if_rdata", bus1.if_rdata,        32'd0);
        rst         = 1'b0;
        last_owner  = 1'b0;
        exp_d_rdata = '0;
        repeat (3) @(negedge clk);
        check_val("abort_no_done", {30'd0, bus1.if_done, bus1.d_done}, 32'd0);
        do_fetch(32'h10);
        do_tie(32'h24, 32'h40);

        // Latency-3 instance: single load.
        @(negedge clk);
        bus3.d_req  = 1'b1;
        bus3.d_we   = 1'b0;
        bus3.d_addr = 32'h80;
        sb3.push_back(32'h80 ^ 32'hA5A5_0000);
        t0  = cyc;
        en3 = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus3.mem_en) en3++;
            if (bus3.d_done) begin
                got = 1'b1;
                break;
            end
        end
        bus3.d_req = 1'b0;
        check_val("l3_done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check_val("l3_latency", cyc - t0, 32'd5);
            check_val("l3_d_rdata", bus3.d_rdata, sb3.pop_front());
        end
        check_val("l3_mem_en_cycles", en3, 32'd1);
        check_val("l3_no_if_done", {31'd0, bus3.if_done}, 32'd0);

        repeat (4) @(negedge clk);
        check_val("sb_drained", sb.size(), 32'd0);
        check_val("mem_en_count", en1_cnt, n_txn + 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end
endmodule
